// File: rtl/loop_ctrl_pkg.sv
// Shared types and sizing for the loop-nest controller and its address-generator consumer.
// Widths are fixed here so every block that imports the package agrees on them.
package loop_ctrl_pkg;

  localparam int LOOP_COUNT_W = 8;
  localparam int INST_ADDR_W  = 4;
  localparam int NUM_LOOPS    = 1 << INST_ADDR_W;

  function automatic int level_w_of(input int addr_w);
    return (addr_w < 1) ? 1 : addr_w;
  endfunction

  localparam int LEVEL_W     = level_w_of(INST_ADDR_W);
  // num_loops and w both span 0..NUM_LOOPS inclusive
  localparam int CNT_LOOPS_W = INST_ADDR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = S_IDLE,
    RUN  = S_RUN,
    DONE = S_DONE
  } state_t;

  typedef struct packed {
    logic [LEVEL_W-1:0] level;
    logic               first;
    logic               last;
  } step_t;

endpackage

// File: rtl/loop_wrap_detect.sv
// Carry chain over the per-level cnt==max flags: w is the number of wrapping levels from 0.
// Purely combinational; levels at or above num_loops break the chain.
module loop_wrap_detect
  import loop_ctrl_pkg::*;
(
  input  logic [NUM_LOOPS-1:0]   i_eq,
  input  logic [CNT_LOOPS_W-1:0] i_num_loops,
  output logic [CNT_LOOPS_W-1:0] o_w,
  output logic                   o_all_wrap
);

  logic w_stop;

  always_comb begin
    o_w    = CNT_LOOPS_W'(NUM_LOOPS);
    w_stop = 1'b0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      if (!w_stop && ((CNT_LOOPS_W'(i) >= i_num_loops) || !i_eq[i])) begin
        o_w    = CNT_LOOPS_W'(i);
        w_stop = 1'b1;
      end
    end
    o_all_wrap = (o_w >= i_num_loops);
  end

endmodule

// File: rtl/loop_nest_controller.sv
// Walks a programmed loop nest, one iteration per accepted step; first step the cycle after start.
// Backpressure: while step_ready is low every step output and iter_vec hold.
module loop_nest_controller
  import loop_ctrl_pkg::*;
(
  input  logic                                i_clk,
  input  logic                                i_reset,
  input  logic                                i_start,
  input  logic                                i_abort,
  output logic                                o_done,
  output logic                                o_busy,
  input  logic                                i_loop_wr_v,
  input  logic [LOOP_COUNT_W-1:0]             i_loop_wr_max_iter,
  input  logic                                i_cfg_clear,
  output logic                                o_cfg_overflow,
  output logic                                o_step_valid,
  input  logic                                i_step_ready,
  output logic [LEVEL_W-1:0]                  o_step_level,
  output logic                                o_step_first,
  output logic                                o_step_last,
  output logic [NUM_LOOPS*LOOP_COUNT_W-1:0]   o_iter_vec
);

  state_t                   r_state;
  logic [LOOP_COUNT_W-1:0]  r_max [NUM_LOOPS];
  logic [LOOP_COUNT_W-1:0]  r_cnt [NUM_LOOPS];
  logic [CNT_LOOPS_W-1:0]   r_num_loops;
  logic                     r_overflow;
  logic                     r_first;
  logic [LEVEL_W-1:0]       r_level;

  logic [NUM_LOOPS-1:0]     w_eq;
  logic [CNT_LOOPS_W-1:0]   w_w;
  logic                     w_all_wrap;
  logic                     w_run;
  step_t                    w_step;

  always_comb begin
    w_eq = '0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      w_eq[i] = (r_cnt[i] == r_max[i]);
    end
  end

  loop_wrap_detect u_wrap (
    .i_eq        (w_eq),
    .i_num_loops (r_num_loops),
    .o_w         (w_w),
    .o_all_wrap  (w_all_wrap)
  );

  assign w_run  = (r_state == RUN);
  assign w_step = '{level: (w_run ? r_level : '0),
                    first: (w_run & r_first),
                    last:  (w_run & w_all_wrap)};

  assign o_step_valid   = w_run;
  assign o_step_level   = w_step.level;
  assign o_step_first   = w_step.first;
  assign o_step_last    = w_step.last;
  assign o_done         = (r_state == DONE);
  assign o_busy         = (r_state != IDLE);
  assign o_cfg_overflow = r_overflow;

  // Levels outside the current program read 0 even if a previous, longer program left them set
  always_comb begin
    o_iter_vec = '0;
    for (int i = 0; i < NUM_LOOPS; i++) begin
      if (CNT_LOOPS_W'(i) < r_num_loops) begin
        o_iter_vec[i*LOOP_COUNT_W +: LOOP_COUNT_W] = r_cnt[i];
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_num_loops <= '0;
      r_overflow  <= 1'b0;
      r_first     <= 1'b0;
      r_level     <= '0;
      for (int i = 0; i < NUM_LOOPS; i++) begin
        r_max[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (i_abort && (r_state != IDLE)) begin
      r_state <= IDLE;
      r_first <= 1'b0;
      r_level <= '0;
      for (int i = 0; i < NUM_LOOPS; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      case (r_state)
        IDLE: begin
          if (i_cfg_clear) begin
            r_num_loops <= '0;
            r_overflow  <= 1'b0;
          end else if (i_loop_wr_v) begin
            if (r_num_loops == CNT_LOOPS_W'(NUM_LOOPS)) begin
              r_overflow <= 1'b1;
            end else begin
              r_max[r_num_loops[INST_ADDR_W-1:0]] <= i_loop_wr_max_iter;
              r_num_loops <= r_num_loops + CNT_LOOPS_W'(1);
            end
          end
          if (i_start && !i_abort) begin
            if (r_num_loops != '0) begin
              r_state <= RUN;
              r_first <= 1'b1;
              r_level <= '0;
              for (int i = 0; i < NUM_LOOPS; i++) begin
                r_cnt[i] <= '0;
              end
            end else begin
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (i_step_ready) begin
            r_first <= 1'b0;
            if (w_all_wrap) begin
              r_state <= DONE;
            end else begin
              r_level <= w_w[LEVEL_W-1:0];
              for (int i = 0; i < NUM_LOOPS; i++) begin
                if (CNT_LOOPS_W'(i) < w_w) begin
                  r_cnt[i] <= '0;
                end else if (CNT_LOOPS_W'(i) == w_w) begin
                  r_cnt[i] <= r_cnt[i] + LOOP_COUNT_W'(1);
                end
              end
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_loop_nest_controller.sv
// Randomised bench for loop_nest_controller against a mixed-radix iteration model.
module tb_loop_nest_controller;
  import loop_ctrl_pkg::*;

  localparam int IVW = NUM_LOOPS * LOOP_COUNT_W;

  logic                    clk = 1'b0;
  logic                    reset, start, abort, done, busy;
  logic                    wr_v, cfg_clear, cfg_overflow;
  logic [LOOP_COUNT_W-1:0] wr_dat;
  logic                    valid, ready, first, last;
  logic [LEVEL_W-1:0]      level;
  logic [IVW-1:0]          iter_vec;

  int total_chk = 0;
  int bad_chk   = 0;
  int g_max [NUM_LOOPS];
  int g_n   = 0;

  always #5 clk = ~clk;

  loop_nest_controller dut (
    .i_clk              (clk),
    .i_reset            (reset),
    .i_start            (start),
    .i_abort            (abort),
    .o_done             (done),
    .o_busy             (busy),
    .i_loop_wr_v        (wr_v),
    .i_loop_wr_max_iter (wr_dat),
    .i_cfg_clear        (cfg_clear),
    .o_cfg_overflow     (cfg_overflow),
    .o_step_valid       (valid),
    .i_step_ready       (ready),
    .o_step_level       (level),
    .o_step_first       (first),
    .o_step_last        (last),
    .o_iter_vec         (iter_vec)
  );

  task automatic chk(input string tag, input logic [IVW-1:0] obs, input logic [IVW-1:0] exp);
    total_chk++;
    if (obs !== exp) begin
      bad_chk++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Iteration k of the nest is k written in mixed radix (max[i]+1), level 0 least significant
  function automatic int digit(input int k, input int i);
    int div = 1;
    for (int j = 0; j < i; j++) div = div * (g_max[j] + 1);
    return (k / div) % (g_max[i] + 1);
  endfunction

  function automatic int nsteps();
    int p = 1;
    for (int j = 0; j < g_n; j++) p = p * (g_max[j] + 1);
    return p;
  endfunction

  function automatic int exp_level(input int k);
    int lv = 0;
    if (k == 0) return 0;
    for (int i = 0; i < g_n; i++)
      if (digit(k, i) != digit(k - 1, i)) lv = i;
    return lv;
  endfunction

  function automatic logic [IVW-1:0] exp_iter(input int k);
    logic [IVW-1:0] v = '0;
    int d;
    for (int i = 0; i < g_n; i++) begin
      d = digit(k, i);
      v[i*LOOP_COUNT_W +: LOOP_COUNT_W] = d[LOOP_COUNT_W-1:0];
    end
    return v;
  endfunction

  task automatic wr(input int v);
    wr_v   = 1'b1;
    wr_dat = v[LOOP_COUNT_W-1:0];
    tick();
    wr_v   = 1'b0;
  endtask

  task automatic do_clear();
    cfg_clear = 1'b1;
    tick();
    cfg_clear = 1'b0;
  endtask

  task automatic load();
    do_clear();
    for (int i = 0; i < g_n; i++) wr(g_max[i]);
  endtask

  // mode 0: always ready, 1: ready every other cycle, 2: random ready
  task automatic run(input int mode, input int abort_after);
    int   total;
    int   k;
    int   cyc;
    logic rdy;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (g_n == 0) begin
      chk("empty_done", done, 1);
      chk("empty_valid", valid, 0);
      tick();
      chk("empty_busy", busy, 0);
      chk("empty_valid2", valid, 0);
      return;
    end
    total = nsteps();
    k     = 0;
    cyc   = 0;
    while (k < total && cyc < total * 4 + 20) begin
      if (abort_after >= 0 && k == abort_after) begin
        abort = 1'b1;
        ready = 1'b0;
        tick();
        abort = 1'b0;
        chk("abort_valid", valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        tick();
        chk("abort_nodone", done, 0);
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = ((cyc % 2) == 1);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      ready = rdy;
      chk("valid", valid, 1);
      chk("busy", busy, 1);
      chk("level", level, exp_level(k));
      chk("first", first, k == 0);
      chk("last", last, k == total - 1);
      chk("iter_vec", iter_vec, exp_iter(k));
      chk("early_done", done, 0);
      tick();
      cyc++;
      if (rdy) k++;
    end
    if (k < total) chk("timeout", k, total);
    ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("done_valid", valid, 0);
    tick();
    chk("done_once", done, 0);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    #4000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; abort = 1'b0; wr_v = 1'b0; wr_dat = '0;
    cfg_clear = 1'b0; ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ovf", cfg_overflow, 0);
    chk("rst_iter", iter_vec, 0);
    chk("rst_step", {level, first, last}, 0);

    // Basic two-level nest, then the same program replayed with stalls
    g_n = 2; g_max[0] = 1; g_max[1] = 2;
    load();
    run(0, -1);
    run(1, -1);

    // Empty program
    g_n = 0;
    load();
    run(0, -1);

    // Abort after three accepted steps, then full replay
    g_n = 2; g_max[0] = 1; g_max[1] = 2;
    load();
    run(0, 3);
    run(0, -1);

    // Fill the program, overflow on the 17th write, verify the retained program
    g_n = NUM_LOOPS;
    for (int i = 0; i < NUM_LOOPS; i++) g_max[i] = (i % 5 == 0) ? 1 : 0;
    load();
    chk("ovf_before", cfg_overflow, 0);
    wr(7);
    chk("ovf_set", cfg_overflow, 1);
    run(2, -1);
    chk("ovf_sticky", cfg_overflow, 1);
    do_clear();
    chk("ovf_clear", cfg_overflow, 0);
    g_n = 0;
    run(0, -1);

    // Degenerate and long single-level nests
    g_n = 3; g_max[0] = 0; g_max[1] = 0; g_max[2] = 0;
    load();
    run(0, -1);
    g_n = 1; g_max[0] = 255;
    load();
    run(0, -1);

    // Random programs with random backpressure and occasional aborts
    for (int t = 0; t < 8; t++) begin
      int ab;
      g_n = $urandom_range(1, 4);
      for (int i = 0; i < g_n; i++) g_max[i] = $urandom_range(0, 3);
      load();
      ab = ($urandom_range(0, 2) == 0) ? $urandom_range(0, nsteps() - 1) : -1;
      run(2, ab);
      if (ab >= 0) run(2, -1);
    end

    // start with abort in IDLE stays IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", busy, 0);
    chk("start_abort_valid", valid, 0);

    // Reset mid-run drops the program
    start = 1'b1;
    tick();
    start = 1'b0;
    ready = 1'b1;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    ready = 1'b0;
    chk("midrst_busy", busy, 0);
    chk("midrst_iter", iter_vec, 0);
    g_n = 0;
    run(0, -1);

    $display("test done: total=%0d bad=%0d", total_chk, bad_chk);
    $finish;
  end

endmodule
